if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register.
- Owns the PC and drives the instruction-memory handshake (wait-state capable).
- Holds one fetched instruction in an output slot and presents PC, PC+4 and the instruction word to IF/ID with a load strobe.
- Honours hazard-unit stalls and branch/jump redirects from later stages.

---
 rtl/if_fetch_stage.sv | 135 +++++++++++++
 tb/tb_if_fetch_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, runs the
// wait-state capable instruction-memory handshake, and holds one fetched
// instruction in an output slot that feeds the IF/ID pipeline register.
//
// Handshake: a fetch completes on any rising edge where imem_req and
// imem_ready are both high. imem_req may drop between cycles (e.g. while
// stalled with a full slot); memory treats every cycle independently, and
// pc/imem_addr stay put until a fetch completes or a redirect arrives.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-low reset
//   stall        in   hazard unit: IF/ID must not load this cycle
//   redirect     in   branch taken / jump from a later stage
//   redirect_pc  in   [31:0] redirect target
//   imem_req     out  fetch request
//   imem_addr    out  [31:0] fetch address (current pc)
//   imem_ready   in   imem_rdata is valid for imem_addr this cycle
//   imem_rdata   in   [31:0] instruction word
//   if_valid     out  output slot holds a valid instruction
//   if_pc        out  [31:0] PC of slot instruction
//   if_pc4       out  [31:0] PC+4 of slot instruction
//   if_instr     out  [31:0] slot instruction (NOP_INSTR when empty)
//   if_ld        out  IF/ID load strobe
//   halted       out  sticky: misaligned redirect seen; mirrors the FSM state
//   fetch_count  out  [31:0] instructions handed to IF/ID
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_instr,
    output logic        if_ld,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        fetch_done;
    logic        redirect_ok;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            if_valid_q    <= 1'b0;
            if_pc_q       <= RESET_PC;
            if_pc4_q      <= RESET_PC + 32'd4;
            if_instr_q    <= NOP_INSTR;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_pc4_q      <= if_pc4_d;
            if_instr_q    <= if_instr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        // A full slot may only be refilled in the same cycle it is consumed,
        // so the request is withheld while stalled with a valid instruction.
        imem_req    = (state_q == ST_RUN) & reset & (~if_valid_q | ~stall);
        if_ld       = if_valid_q & ~stall & ~redirect;
        fetch_done  = imem_req & imem_ready;
        redirect_ok = (redirect_pc[1:0] == 2'b00);

        state_d       = state_q;
        pc_d          = pc_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_pc4_d      = if_pc4_q;
        if_instr_d    = if_instr_q;
        fetch_count_d = if_ld ? fetch_count_q + 32'd1 : fetch_count_q;

        if (redirect && redirect_ok) begin
            // Redirect beats stall and drops any response arriving this edge.
            pc_d       = redirect_pc;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (redirect) begin
            // Misaligned target: stop fetching for good until reset.
            state_d    = ST_HALT;
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else if (fetch_done) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_pc4_d   = pc_q + 32'd4;
            if_valid_d = 1'b1;
            pc_d       = pc_q + 32'd4;
        end else if (if_ld) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = if_valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc4      = if_pc4_q;
    assign if_instr    = if_instr_q;
    assign halted      = (state_q == ST_HALT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Bench for if_fetch_stage. Inputs change just after the falling edge; both
// the scoreboard process and the directed literal checks sample 2 time units
// later, well before the next rising edge. A behavioural model of the fetch
// stage (pc, slot contents, halt flag, handoff count) advances on each rising
// edge from the same inputs and supplies expected outputs.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_instr;
    logic        if_ld;
    logic        halted;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    if_fetch_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_instr    (if_instr),
        .if_ld       (if_ld),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    // Instruction memory contents: a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h2400_5A00;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // ---------------- behavioural model ----------------
    logic        m_init = 1'b0;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_halted;
    logic [31:0] m_count;

    function automatic logic exp_ld();
        return m_valid & ~stall & ~redirect;
    endfunction

    function automatic logic exp_req();
        return ~m_halted & reset & (~m_valid | ~stall);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_init   = 1'b1;
            m_pc     = RST_PC;
            m_valid  = 1'b0;
            m_instr  = NOP;
            m_ipc    = RST_PC;
            m_halted = 1'b0;
            m_count  = 32'd0;
        end else if (m_init) begin
            logic took;
            logic got;
            took = exp_ld();
            got  = exp_req() & imem_ready;
            if (took) m_count = m_count + 32'd1;
            if (redirect) begin
                m_valid = 1'b0;
                m_instr = NOP;
                if (redirect_pc[1:0] == 2'b00) m_pc = redirect_pc;
                else m_halted = 1'b1;
            end else if (got) begin
                m_instr = mem_word(m_pc);
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end else if (took) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (m_init) begin
            chk("sb_imem_req",    {31'd0, imem_req}, {31'd0, exp_req()});
            chk("sb_imem_addr",   imem_addr,         m_pc);
            chk("sb_if_valid",    {31'd0, if_valid}, {31'd0, m_valid});
            chk("sb_if_instr",    if_instr,          m_instr);
            chk("sb_if_pc",       if_pc,             m_ipc);
            chk("sb_if_pc4",      if_pc4,            m_ipc + 32'd4);
            chk("sb_if_ld",       {31'd0, if_ld},    {31'd0, exp_ld()});
            chk("sb_halted",      {31'd0, halted},   {31'd0, m_halted});
            chk("sb_fetch_count", fetch_count,       m_count);
        end
    end

    // ---------------- driver ----------------
    // Apply inputs for the upcoming rising edge and settle before checks.
    task automatic cyc(input logic rst_n, input logic st, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset       = rst_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        #2;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        // Reset, zero-wait memory.
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("req_low_in_reset", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_if_valid",    {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc4",      if_pc4,      32'h0040_0004);
        chk("rst_fetch_count", fetch_count, 32'd0);
        chk("rst_imem_addr",   imem_addr,   32'h0040_0000);

        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("c1_addr", imem_addr, 32'h0040_0000);
        chk("c1_req",  {31'd0, imem_req}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("c2_addr", imem_addr, 32'h0040_0004);
        chk("c2_ld",   {31'd0, if_ld}, 32'd1);
        chk("c2_pc",   if_pc, 32'h0040_0000);

        // Wait states on the fetch at 0x400008.
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("c3_addr",  imem_addr, 32'h0040_0008);
        chk("c3_pc4",   if_pc4,    32'h0040_0008);
        chk("c3_count", fetch_count, 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("w1_valid", {31'd0, if_valid}, 32'd0);
        chk("w1_addr",  imem_addr, 32'h0040_0008);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("w2_valid", {31'd0, if_valid}, 32'd0);
        chk("w2_addr",  imem_addr, 32'h0040_0008);

        // Stall for 3 cycles while the slot holds 0x400008.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
            chk("st_req",   {31'd0, imem_req}, 32'd0);
            chk("st_ld",    {31'd0, if_ld}, 32'd0);
            chk("st_pc",    if_pc, 32'h0040_0008);
            chk("st_instr", if_instr, mem_word(32'h0040_0008));
            chk("st_count", fetch_count, 32'd2);
        end
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("unst_addr", imem_addr, 32'h0040_000C);
        chk("unst_req",  {31'd0, imem_req}, 32'd1);

        // Redirect concurrent with stall and ready.
        cyc(1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b1);
        chk("rd_ld", {31'd0, if_ld}, 32'd0);
        chk("rd_pc", if_pc, 32'h0040_000C);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rd_valid", {31'd0, if_valid}, 32'd0);
        chk("rd_addr",  imem_addr, 32'h0040_0100);
        chk("rd_count", fetch_count, 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("rd_ifpc", if_pc, 32'h0040_0100);

        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("wrap_pc",   if_pc,     32'hFFFF_FFFC);
        chk("wrap_pc4",  if_pc4,    32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Misaligned redirect halts until reset.
        cyc(1'b1, 1'b0, 1'b1, 32'h0040_0102, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_req",  {31'd0, imem_req}, 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("unhalt_flag", {31'd0, halted}, 32'd0);
        chk("unhalt_addr", imem_addr, 32'h0040_0000);
        chk("unhalt_req",  {31'd0, imem_req}, 32'd1);

        // Random traffic; the scoreboard checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_st, r_rd, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) != 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_rd  = ($urandom_range(0, 15) == 0);
            r_rdy = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       r_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                1:       r_pc = $urandom;
                default: r_pc = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            endcase
            // Keep halts rare so most of the run exercises fetching.
            if (r_rd && r_pc[1:0] != 2'b00 && $urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
            cyc(r_rst, r_st, r_rd, r_pc, r_rdy);
        end

        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
